// File: rtl/diffeq_solver_fx.sv
// Fixed-point Euler solver for y'' + 3xy' + 3y = 0.
// The datapath uses one shared saturating multiplier and one shared adder, sequenced by a Moore FSM.
module diffeq_solver_fx #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int MAX_ITER = 255,
    localparam int ITER_W  = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  x_in,
    input  logic [WIDTH-1:0]  u_in,
    input  logic [WIDTH-1:0]  y_in,
    input  logic [WIDTH-1:0]  dx_in,
    input  logic [WIDTH-1:0]  a_in,
    output logic [WIDTH-1:0]  x_out,
    output logic [WIDTH-1:0]  u_out,
    output logic [WIDTH-1:0]  y_out,
    output logic [ITER_W-1:0] iter_out,
    output logic              busy,
    output logic              done,
    output logic              sat,
    output logic              iter_limit
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MUL_A = 3'd2,
        MUL_B = 3'd3,
        MUL_C = 3'd4,
        SUM   = 3'd5,
        UPD   = 3'd6,
        DONE  = 3'd7
    } state_t;

    localparam logic [WIDTH-1:0] VMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] VMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Helper results are packed as {overflow, value}.
    function automatic logic [WIDTH:0] sat_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] ae;
        logic signed [2*WIDTH-1:0] be;
        logic signed [2*WIDTH-1:0] p;
        ae = {{WIDTH{a[WIDTH-1]}}, a};
        be = {{WIDTH{b[WIDTH-1]}}, b};
        p  = ae * be;
        p  = p >>> FRAC;
        if (p[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){p[2*WIDTH-1]}}) begin
            return {1'b0, p[WIDTH-1:0]};
        end else if (p[2*WIDTH-1]) begin
            return {1'b1, VMIN};
        end else begin
            return {1'b1, VMAX};
        end
    endfunction

    function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] == s[WIDTH-1]) begin
            return {1'b0, s[WIDTH-1:0]};
        end else if (s[WIDTH]) begin
            return {1'b1, VMIN};
        end else begin
            return {1'b1, VMAX};
        end
    endfunction

    function automatic logic [WIDTH:0] sat_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (s[WIDTH] == s[WIDTH-1]) begin
            return {1'b0, s[WIDTH-1:0]};
        end else if (s[WIDTH]) begin
            return {1'b1, VMIN};
        end else begin
            return {1'b1, VMAX};
        end
    endfunction

    // The multiply by three is formed as s + 2s, which needs two guard bits.
    function automatic logic [WIDTH:0] sat_triple(input logic [WIDTH-1:0] a);
        logic [WIDTH+1:0] ae;
        logic [WIDTH+1:0] t;
        ae = {{2{a[WIDTH-1]}}, a};
        t  = ae + (ae << 1);
        if (t[WIDTH+1:WIDTH-1] == {3{t[WIDTH+1]}}) begin
            return {1'b0, t[WIDTH-1:0]};
        end else if (t[WIDTH+1]) begin
            return {1'b1, VMIN};
        end else begin
            return {1'b1, VMAX};
        end
    endfunction

    state_t state_r;
    state_t next_state_s;

    logic [WIDTH-1:0]  x_r, u_r, y_r, dx_r, a_r;
    logic [WIDTH-1:0]  xn_r, yn_r, t1_r, t2_r, t3_r, s_r;
    logic [ITER_W-1:0] iter_r;
    logic              sat_r;

    logic [WIDTH-1:0]  mul_op_a_s, mul_op_b_s, add_op_a_s, add_op_b_s;
    logic [WIDTH:0]    mul_res_s, add_res_s, tri_res_s, upd_res_s;
    logic              x_ge_a_s, lim_hit_s;

    assign x_ge_a_s  = ($signed(x_r) >= $signed(a_r));
    assign lim_hit_s = (iter_r == ITER_W'(MAX_ITER));
    assign mul_res_s = sat_mul(mul_op_a_s, mul_op_b_s);
    assign add_res_s = sat_add(add_op_a_s, add_op_b_s);
    assign tri_res_s = sat_triple(s_r);
    assign upd_res_s = sat_sub(u_r, tri_res_s[WIDTH-1:0]);

    // Operand steering for the shared multiplier and adder
    always_comb begin
        mul_op_a_s = '0;
        mul_op_b_s = '0;
        add_op_a_s = '0;
        add_op_b_s = '0;
        case (state_r)
            MUL_A: begin
                mul_op_a_s = u_r;
                mul_op_b_s = dx_r;
                add_op_a_s = x_r;
                add_op_b_s = dx_r;
            end
            MUL_B: begin
                mul_op_a_s = x_r;
                mul_op_b_s = t1_r;
                add_op_a_s = y_r;
                add_op_b_s = t1_r;
            end
            MUL_C: begin
                mul_op_a_s = y_r;
                mul_op_b_s = dx_r;
            end
            SUM: begin
                add_op_a_s = t2_r;
                add_op_b_s = t3_r;
            end
            default: begin
                mul_op_a_s = '0;
                mul_op_b_s = '0;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = CHECK;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CHECK: begin
                if (x_ge_a_s || lim_hit_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = MUL_A;
                end
            end
            MUL_A:   next_state_s = MUL_B;
            MUL_B:   next_state_s = MUL_C;
            MUL_C:   next_state_s = SUM;
            SUM:     next_state_s = UPD;
            UPD:     next_state_s = CHECK;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Working registers, result registers and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r        <= '0;
            u_r        <= '0;
            y_r        <= '0;
            dx_r       <= '0;
            a_r        <= '0;
            xn_r       <= '0;
            yn_r       <= '0;
            t1_r       <= '0;
            t2_r       <= '0;
            t3_r       <= '0;
            s_r        <= '0;
            iter_r     <= '0;
            sat_r      <= 1'b0;
            x_out      <= '0;
            u_out      <= '0;
            y_out      <= '0;
            iter_out   <= '0;
            sat        <= 1'b0;
            iter_limit <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (next_state_s != IDLE);
            done <= (state_r == CHECK) && (next_state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        x_r    <= x_in;
                        u_r    <= u_in;
                        y_r    <= y_in;
                        dx_r   <= dx_in;
                        a_r    <= a_in;
                        iter_r <= '0;
                        sat_r  <= 1'b0;
                    end
                end
                CHECK: begin
                    // Results are published on the edge entering DONE so they line up with done.
                    if (x_ge_a_s || lim_hit_s) begin
                        x_out      <= x_r;
                        u_out      <= u_r;
                        y_out      <= y_r;
                        iter_out   <= iter_r;
                        sat        <= sat_r;
                        iter_limit <= !x_ge_a_s;
                    end
                end
                MUL_A: begin
                    t1_r  <= mul_res_s[WIDTH-1:0];
                    xn_r  <= add_res_s[WIDTH-1:0];
                    sat_r <= sat_r | mul_res_s[WIDTH] | add_res_s[WIDTH];
                end
                MUL_B: begin
                    t2_r  <= mul_res_s[WIDTH-1:0];
                    yn_r  <= add_res_s[WIDTH-1:0];
                    sat_r <= sat_r | mul_res_s[WIDTH] | add_res_s[WIDTH];
                end
                MUL_C: begin
                    t3_r  <= mul_res_s[WIDTH-1:0];
                    sat_r <= sat_r | mul_res_s[WIDTH];
                end
                SUM: begin
                    s_r   <= add_res_s[WIDTH-1:0];
                    sat_r <= sat_r | add_res_s[WIDTH];
                end
                UPD: begin
                    x_r    <= xn_r;
                    y_r    <= yn_r;
                    u_r    <= upd_res_s[WIDTH-1:0];
                    iter_r <= iter_r + 1'b1;
                    sat_r  <= sat_r | tri_res_s[WIDTH] | upd_res_s[WIDTH];
                end
                default: begin
                    sat_r <= sat_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diffeq_solver_fx.sv
// Scoreboard bench for diffeq_solver_fx: the driver pushes reference results computed with plain
// integer arithmetic, and a monitor pops and compares them on every done pulse.
module tb_diffeq_solver_fx;

    localparam int WIDTH    = 16;
    localparam int FRAC     = 8;
    localparam int MAX_ITER = 4;
    localparam int ITER_W   = $clog2(MAX_ITER + 1);
    localparam longint VMAXL = 32767;
    localparam longint VMINL = -32768;

    typedef struct {
        logic [15:0] x;
        logic [15:0] u;
        logic [15:0] y;
        int          iter;
        bit          sat;
        bit          lim;
        longint      cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  x_in = '0, u_in = '0, y_in = '0, dx_in = '0, a_in = '0;
    logic [WIDTH-1:0]  x_out, u_out, y_out;
    logic [ITER_W-1:0] iter_out;
    logic              busy, done, sat, iter_limit;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    exp_t   q[$];

    diffeq_solver_fx #(.WIDTH(WIDTH), .FRAC(FRAC), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_in(x_in), .u_in(u_in), .y_in(y_in), .dx_in(dx_in), .a_in(a_in),
        .x_out(x_out), .u_out(u_out), .y_out(y_out), .iter_out(iter_out),
        .busy(busy), .done(done), .sat(sat), .iter_limit(iter_limit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit ovf(input longint v);
        return (v > VMAXL) || (v < VMINL);
    endfunction

    function automatic longint clampv(input longint v);
        if (v > VMAXL) return VMAXL;
        if (v < VMINL) return VMINL;
        return v;
    endfunction

    function automatic longint mulq(input longint a, input longint b);
        longint p;
        p = a * b;
        return p >>> FRAC;
    endfunction

    // Reference: the benchmark loop in Q8.8 with saturation after every operation.
    function automatic exp_t model(input logic signed [15:0] xi, input logic signed [15:0] ui,
                                   input logic signed [15:0] yi, input logic signed [15:0] dxi,
                                   input logic signed [15:0] ai);
        exp_t   e;
        longint x, u, y, dx, a, t1, t2, t3, sm, tr, v, xn, yn;
        int     n;
        bit     s, lim;
        x = longint'(xi); u = longint'(ui); y = longint'(yi);
        dx = longint'(dxi); a = longint'(ai);
        n = 0; s = 1'b0; lim = 1'b0;
        while (1) begin
            if (x >= a) break;
            if (n == MAX_ITER) begin
                lim = 1'b1;
                break;
            end
            v  = mulq(u, dx); s |= ovf(v); t1 = clampv(v);
            v  = x + dx;      s |= ovf(v); xn = clampv(v);
            v  = mulq(x, t1); s |= ovf(v); t2 = clampv(v);
            v  = y + t1;      s |= ovf(v); yn = clampv(v);
            v  = mulq(y, dx); s |= ovf(v); t3 = clampv(v);
            v  = t2 + t3;     s |= ovf(v); sm = clampv(v);
            v  = 3 * sm;      s |= ovf(v); tr = clampv(v);
            v  = u - tr;      s |= ovf(v); u  = clampv(v);
            x = xn; y = yn; n++;
        end
        e.x = 16'(x); e.u = 16'(u); e.y = 16'(y);
        e.iter = n; e.sat = s; e.lim = lim; e.cyc = 0;
        return e;
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout busy still %0b after %0d cycles (want 0)", busy, k);
        end
    endtask

    // Starts a run with expected result e; optionally pokes start twice while busy.
    task automatic issue(input logic [15:0] xi, input logic [15:0] ui, input logic [15:0] yi,
                         input logic [15:0] dxi, input logic [15:0] ai, input exp_t e_in,
                         input bit pulses);
        exp_t e;
        e = e_in;
        wait_idle();
        x_in = xi; u_in = ui; y_in = yi; dx_in = dxi; a_in = ai;
        start = 1'b1;
        e.cyc = cyc + 1 + 1 + 6 * e.iter;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (pulses) begin
            @(negedge clk);
            @(negedge clk);
            x_in = 16'($urandom); u_in = 16'($urandom); a_in = 16'h7FFF;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            y_in = 16'($urandom); dx_in = 16'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic issue_model(input logic [15:0] xi, input logic [15:0] ui, input logic [15:0] yi,
                               input logic [15:0] dxi, input logic [15:0] ai);
        issue(xi, ui, yi, dxi, ai, model(xi, ui, yi, dxi, ai), 1'b0);
    endtask

    function automatic logic [15:0] rnd_small();
        return 16'(int'($urandom_range(0, 1024)) - 512);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done got done=1 at cycle %0d, want no pulse", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (x_out !== e.x || u_out !== e.u || y_out !== e.y || int'(iter_out) != e.iter ||
                    sat !== e.sat || iter_limit !== e.lim || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL run_result got x=%h u=%h y=%h iter=%0d sat=%0b lim=%0b cyc=%0d want x=%h u=%h y=%h iter=%0d sat=%0b lim=%0b cyc=%0d",
                             x_out, u_out, y_out, iter_out, sat, iter_limit, cyc,
                             e.x, e.u, e.y, e.iter, e.sat, e.lim, e.cyc);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || x_out !== 16'h0000 || u_out !== 16'h0000 ||
            y_out !== 16'h0000 || iter_out !== '0 || sat !== 1'b0 || iter_limit !== 1'b0) begin
            failures++;
            $display("FAIL %s got busy=%0b done=%0b x=%h u=%h y=%h iter=%0d sat=%0b lim=%0b want all zero",
                     name, busy, done, x_out, u_out, y_out, iter_out, sat, iter_limit);
        end
    endtask

    initial begin
        exp_t t1;
        int   k;
        t1.x = 16'h0040; t1.u = 16'h00E8; t1.y = 16'h0040;
        t1.iter = 2; t1.sat = 1'b0; t1.lim = 1'b0; t1.cyc = 0;

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b1;

        issue(16'h0000, 16'h0100, 16'h0000, 16'h0020, 16'h0040, t1, 1'b0);
        issue_model(16'h0100, 16'h1234, 16'hFF00, 16'h0020, 16'h0040);
        issue_model(16'h0000, 16'h0100, 16'h0080, 16'h0000, 16'h0100);
        issue_model(16'h0000, 16'h7F00, 16'h7F00, 16'h0100, 16'h0080);
        issue(16'h0000, 16'h0100, 16'h0000, 16'h0020, 16'h0040, t1, 1'b1);
        issue_model(16'h0000, 16'h0100, 16'h0000, 16'hFFF0, 16'h0040);

        // Abort during MUL_B: issue returns one cycle into the run.
        issue(16'h0000, 16'h0100, 16'h0000, 16'h0020, 16'h0040, t1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero("reset_mid_run");
        void'(q.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        issue(16'h0000, 16'h0100, 16'h0000, 16'h0020, 16'h0040, t1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 3) begin
                issue_model(rnd_small(), 16'($urandom), 16'($urandom), 16'($urandom_range(0, 1024)),
                            16'($urandom_range(0, 2048)));
            end else begin
                issue_model(rnd_small(), rnd_small(), rnd_small(), rnd_small(), rnd_small());
            end
        end

        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got %0d outstanding runs, want 0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
